// File: rtl/register_file_sync.sv
// DATA_WIDTH x 2^ADDR_WIDTH register file: two registered write-first read ports, one write port,
// and a one-entry-per-cycle clear engine. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  ctrl_reset,
   input  logic                  ctrl_writeEnable,
   input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0] data_writeReg,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
   input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
   output logic [DATA_WIDTH-1:0] data_readRegA,
   output logic [DATA_WIDTH-1:0] data_readRegB,
   input  logic                  ctrl_clear,
   output logic                  clear_busy,
   output logic                  dbg_state_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
   logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;
   logic                  clr_active;
   logic                  wr_accept;

   assign clr_active = (state_q == S_CLEAR);

`ifdef REGFILE_ZERO_REG_EN
   assign wr_accept = ctrl_writeEnable && (state_q == S_IDLE) && !ctrl_clear &&
                      (ctrl_writeReg != '0);
`else
   assign wr_accept = ctrl_writeEnable && (state_q == S_IDLE) && !ctrl_clear;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (ctrl_clear) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end
         end
         S_CLEAR: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read data reflects the array after this edge's update (clear or write), i.e. write-first.
   always_comb begin
      rd_a_d = mem_q[ctrl_readRegA];
      rd_b_d = mem_q[ctrl_readRegB];
      if (wr_accept && (ctrl_writeReg == ctrl_readRegA)) rd_a_d = data_writeReg;
      if (wr_accept && (ctrl_writeReg == ctrl_readRegB)) rd_b_d = data_writeReg;
      if (clr_active && (cnt_q == ctrl_readRegA)) rd_a_d = '0;
      if (clr_active && (cnt_q == ctrl_readRegB)) rd_b_d = '0;
`ifdef REGFILE_ZERO_REG_EN
      if (ctrl_readRegA == '0) rd_a_d = '0;
      if (ctrl_readRegB == '0) rd_b_d = '0;
`endif
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         rd_a_q  <= '0;
         rd_b_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d == S_CLEAR);
         rd_a_q  <= rd_a_d;
         rd_b_q  <= rd_b_d;
      end
   end

   // The clear engine owns the array; writes are already gated off while it runs.
   always_ff @(posedge clock) begin
      if (!ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_active) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_accept) begin
         mem_q[ctrl_writeReg] <= data_writeReg;
      end
   end

   assign data_readRegA = rd_a_q;
   assign data_readRegB = rd_b_q;
   assign clear_busy    = busy_q;
   assign dbg_state_o   = state_q;

endmodule
